// File: rtl/zamarine_pkg.sv
// Zamarine component sequencer: shared types and sizing.
// Build option ZAMARINE_SEQ_STATUS_CHECK_EN is consumed by the top.
package zamarine_pkg;
  localparam int ZAMARINE_MAX_COMPONENTS = 8;
  localparam int ZAMARINE_SETTLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    SETTLE,
    DONE
  } seq_state_e;
endpackage

// File: rtl/zamarine_component_sequencer_if.sv
// Zamarine sequencer bus: request handshake, status feed,
// command strobe and completion reporting.
interface zamarine_component_sequencer_if #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
);
  logic            req_valid;
  logic            req_ready;
  logic [N-1:0]    req_target;
  logic            abort;
  logic [N-1:0]    status_in;
  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_activate;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output req_valid, req_target, abort, status_in,
    input  req_ready, cmd_valid, cmd_id, cmd_activate,
    input  busy, done, err
  );

  modport slave (
    input  req_valid, req_target, abort, status_in,
    output req_ready, cmd_valid, cmd_id, cmd_activate,
    output busy, done, err
  );
endinterface

// File: rtl/zamarine_pick_id.sv
// Priority picker: deactivations first (highest index wins),
// then activations (lowest index wins).
module zamarine_pick_id #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    pending,
  input  logic [N-1:0]    target,
  output logic [ID_W-1:0] id,
  output logic            act,
  output logic            any
);
  logic [N-1:0] off_m;
  logic [N-1:0] on_m;

  assign off_m = pending & ~target;
  assign on_m  = pending & target;

  // Select the next component to move toward the target.
  always_comb begin
    id  = '0;
    act = 1'b0;
    any = |pending;
    if (|off_m) begin
      for (int i = 0; i < N; i++)
        if (off_m[i]) id = ID_W'(i);
    end else begin
      act = |on_m;
      for (int i = N - 1; i >= 0; i--)
        if (on_m[i]) id = ID_W'(i);
    end
  end
endmodule

// File: rtl/zamarine_component_sequencer.sv
// Steps components one at a time toward a target enable mask.
// Define ZAMARINE_SEQ_STATUS_CHECK_EN to enable the post-settle check.
module zamarine_component_sequencer
  import zamarine_pkg::*;
#(
  parameter int MAX_COMPONENTS = ZAMARINE_MAX_COMPONENTS,
  parameter int ID_W           = $clog2(MAX_COMPONENTS),
  parameter int SETTLE_CYCLES  = 4
) (
  input logic clk,
  input logic reset,
  zamarine_component_sequencer_if.slave bus
);
  localparam int W = MAX_COMPONENTS;
  localparam int CW = ZAMARINE_SETTLE_W;

  seq_state_e      state_q, state_d;
  logic [W-1:0]    target_q, target_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic            cur_act_q, cur_act_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [W-1:0]    pending;
  logic [ID_W-1:0] pick_id;
  logic            pick_act;
  logic            pick_any;

  assign pending = target_q ^ bus.status_in;

  zamarine_pick_id #(
    .N    (W),
    .ID_W (ID_W)
  ) u_pick (
    .pending (pending),
    .target  (target_q),
    .id      (pick_id),
    .act     (pick_act),
    .any     (pick_any)
  );

  // State and working registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cur_id_q  <= '0;
      cur_act_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_id_q  <= cur_id_d;
      cur_act_q <= cur_act_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_id_d  = cur_id_q;
    cur_act_d = cur_act_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          target_d = bus.req_target;
          err_d    = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!pick_any) begin
          state_d = DONE;
        end else begin
          cur_id_d  = pick_id;
          cur_act_d = pick_act;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = bus.abort ? IDLE : SETTLE;
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
`ifdef ZAMARINE_SEQ_STATUS_CHECK_EN
          if (bus.status_in[cur_id_q] != cur_act_q)
            err_d = 1'b1;
`else
          err_d = 1'b0;
`endif
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.cmd_valid    = (state_q == ISSUE);
  assign bus.cmd_id       = cur_id_q;
  assign bus.cmd_activate = cur_act_q;
  assign bus.done         = (state_q == DONE);
  assign bus.err          = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_zamarine_component_sequencer.sv
// Scoreboard bench for zamarine_component_sequencer.
// A behavioural register model closes the status loop.
module tb_zamarine_component_sequencer;
`ifdef ZAMARINE_SEQ_STATUS_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  typedef struct {
    bit       is_done;
    bit [2:0] id;
    bit       act;
    bit       err;
    int       cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   passed = 0;
  ev_t  q[$];

  logic [7:0] reg_q = 8'h00;
  logic       ld = 1'b0;
  logic [7:0] ld_val = 8'h00;
  logic       hold0 = 1'b0;

  zamarine_component_sequencer_if #(.N(8)) bus ();

  zamarine_component_sequencer #(
    .MAX_COMPONENTS (8),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Component register model written by the command strobe.
  always @(posedge clk) begin
    if (ld) reg_q <= ld_val;
    else if (bus.cmd_valid) reg_q[bus.cmd_id] <= bus.cmd_activate;
  end

  assign bus.status_in = reg_q & ~{7'b0, hold0};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int pack(input bit d, input bit e,
                              input bit a, input bit [2:0] i);
    return {26'd0, d, e, a, i};
  endfunction

  // Monitor: pop and compare on every command strobe or done pulse.
  always @(negedge clk) begin
    if (!reset && (bus.cmd_valid || bus.done)) begin
      if (q.size() == 0) begin
        chk("unexpected_event",
            pack(bus.done, bus.err, bus.cmd_activate, bus.cmd_id), -1);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.is_done)
          chk("done_fields", pack(bus.done, bus.err, 1'b0, 3'd0),
              pack(1'b1, e.err, 1'b0, 3'd0));
        else
          chk("cmd_fields",
              pack(bus.done, 1'b0, bus.cmd_activate, bus.cmd_id),
              pack(1'b0, 1'b0, e.act, e.id));
        chk("event_cycle", cyc - base, e.cyc);
      end
    end
  end

  task automatic push_cmd(input bit [2:0] id, input bit act, input int c);
    ev_t e;
    e.is_done = 1'b0; e.id = id; e.act = act; e.err = 1'b0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_done(input bit err, input int c);
    ev_t e;
    e.is_done = 1'b1; e.id = 3'd0; e.act = 1'b0; e.err = err; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic set_status(input logic [7:0] v);
    @(negedge clk); ld = 1'b1; ld_val = v;
    @(negedge clk); ld = 1'b0;
  endtask

  // Leaves the bench at the negedge of c1.
  task automatic start(input logic [7:0] tgt);
    @(negedge clk);
    chk("req_ready_before_start", int'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_target = tgt;
    base = cyc;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_target = 8'hFF;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_target = 8'h00;
    bus.abort      = 1'b0;
    #1;
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_cmd_id", int'(bus.cmd_id), 0);
    chk("rst_cmd_act", int'(bus.cmd_activate), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(bus.req_ready), 1);

    // 1: two activations, lowest index first.
    set_status(8'h00);
    start(8'h05);
    push_cmd(3'd0, 1'b1, 2);
    push_cmd(3'd2, 1'b1, 8);
    push_done(1'b0, 14);
    wait_idle("t1_complete");
    chk("t1_status", int'(bus.status_in), 8'h05);

    // 2: single deactivation.
    set_status(8'h81);
    start(8'h01);
    push_cmd(3'd7, 1'b0, 2);
    push_done(1'b0, 8);
    wait_idle("t2_complete");
    chk("t2_status", int'(bus.status_in), 8'h01);

    // 3: deactivations high-first, then activations low-first.
    set_status(8'h0C);
    start(8'h03);
    push_cmd(3'd3, 1'b0, 2);
    push_cmd(3'd2, 1'b0, 8);
    push_cmd(3'd0, 1'b1, 14);
    push_cmd(3'd1, 1'b1, 20);
    push_done(1'b0, 26);
    wait_idle("t3_complete");
    chk("t3_status", int'(bus.status_in), 8'h03);

    // 4: nothing pending.
    set_status(8'h5A);
    start(8'h5A);
    push_done(1'b0, 2);
    chk("t4_ready_c1", int'(bus.req_ready), 0);
    @(negedge clk);
    chk("t4_ready_c2", int'(bus.req_ready), 0);
    @(negedge clk);
    chk("t4_ready_c3", int'(bus.req_ready), 1);

    // 5: abort during the first settle window.
    set_status(8'h00);
    start(8'h05);
    push_cmd(3'd0, 1'b1, 2);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_busy_after_abort", int'(bus.busy), 0);
    chk("t5_ready_after_abort", int'(bus.req_ready), 1);
    repeat (20) @(negedge clk);
    chk("t5_status", int'(bus.status_in), 8'h01);

    // 6: component bit 0 stuck low through the check.
    set_status(8'h00);
    hold0 = 1'b1;
    start(8'h01);
    push_cmd(3'd0, 1'b1, 2);
    push_done(EXP_ERR[0], 8);
    repeat (6) @(negedge clk);
    hold0 = 1'b0;
    wait_idle("t6_complete");

    // 6b: async reset while a command is strobed.
    set_status(8'h00);
    start(8'h01);
    @(posedge clk);
    #1;
    chk("t6b_cmd_valid_in_issue", int'(bus.cmd_valid), 1);
    reset = 1'b1;
    #1;
    chk("t6b_cmd_valid_on_reset", int'(bus.cmd_valid), 0);
    chk("t6b_busy_on_reset", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6b_ready_after_release", int'(bus.req_ready), 1);
    repeat (10) @(negedge clk);
    chk("t6b_no_cmd_after_reset", int'(bus.busy), 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
